// File: rtl/fft_pkg.sv
// fft_pkg -- shared constants and types for the FFT control path.
//   NUMSTAGES_DEF : default number of radix-2 stages (log2 of transform size)
//   BFLY_LAT_DEF  : default butterfly pipeline latency in cycles
//   STAGE0..4     : stage-number constants on the 3-bit stage bus
//   seq_state_t   : stage_sequencer state encoding
package fft_pkg;

  localparam int NUMSTAGES_DEF = 5;
  localparam int BFLY_LAT_DEF  = 2;

  localparam logic [2:0] STAGE0 = 3'b000;
  localparam logic [2:0] STAGE1 = 3'b001;
  localparam logic [2:0] STAGE2 = 3'b010;
  localparam logic [2:0] STAGE3 = 3'b011;
  localparam logic [2:0] STAGE4 = 3'b100;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'b00,
    SEQ_READ  = 2'b01,
    SEQ_DRAIN = 2'b10,
    SEQ_DONE  = 2'b11
  } seq_state_t;

  // True when stage is the final stage of a numstages-stage transform.
  function automatic logic is_last_stage(input logic [2:0] stage, input int numstages);
    return (stage == 3'(numstages - 1));
  endfunction

endpackage

// File: rtl/ctrl_delay_line.sv
// ctrl_delay_line -- fixed-depth shift register for control words.
//   clk  : clock
//   clr  : synchronous clear of every tap (takes priority over en)
//   en   : shift enable; when low all taps hold
//   din  : word entering the line
//   dout : word that entered DEPTH enabled cycles earlier
module ctrl_delay_line #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] taps [DEPTH];

  // Shift the taps, or wipe them all so nothing stale survives a clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        taps[i] <= {WIDTH{1'b0}};
      end
    end else if (en) begin
      taps[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        taps[i] <= taps[i-1];
      end
    end
  end

  assign dout = taps[DEPTH-1];

endmodule

// File: rtl/stage_sequencer.sv
// stage_sequencer -- drives the read and write sides of an in-place
// radix-2 FFT. Each stage reads 2^(NUMSTAGES-2) bank addresses, then
// drains for BFLY_LAT cycles so that every write of the stage lands
// before the next stage begins reading.
//   clk, rst          : clock, synchronous active-high reset
//   start             : run one transform (only honoured in IDLE)
//   stall             : freeze the whole sequencer (STAGE_SEQ_STALL_EN only)
//   ready / busy      : IDLE / not IDLE
//   done              : one-cycle pulse at completion
//   counter, stage_num, rd_en        : read-side control
//   wr_counter, wr_stage, wr_en      : read-side control delayed BFLY_LAT
// Optional feature macro: STAGE_SEQ_STALL_EN adds the stall input.
module stage_sequencer
  import fft_pkg::*;
#(
  parameter int NUMSTAGES = NUMSTAGES_DEF,
  parameter int BFLY_LAT  = BFLY_LAT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
`ifdef STAGE_SEQ_STALL_EN
  input  logic                 stall,
`endif
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [NUMSTAGES-3:0] counter,
  output logic [2:0]           stage_num,
  output logic                 rd_en,
  output logic [NUMSTAGES-3:0] wr_counter,
  output logic [2:0]           wr_stage,
  output logic                 wr_en
);

  localparam int              CW         = NUMSTAGES - 2;
  localparam int              DW         = 1 + CW + 3;
  localparam logic [CW-1:0]   CNT_MAX    = {CW{1'b1}};
  localparam logic [CW-1:0]   CNT_ONE    = CW'(1'b1);
  localparam logic [2:0]      DRAIN_LAST = 3'(BFLY_LAT - 1);

  seq_state_t      state;
  seq_state_t      next_state;
  logic [2:0]      drain_cnt;
  logic            advance;

  logic            rd_en_q;
  logic            done_q;
  logic            ready_q;
  logic            busy_q;
  logic            rd_en_nxt;
  logic            done_nxt;
  logic            ready_nxt;

  logic [DW-1:0]   dl_in;
  logic [DW-1:0]   dl_out;
  logic            wr_en_raw;

`ifdef STAGE_SEQ_STALL_EN
  assign advance = ~stall;
`else
  assign advance = 1'b1;
`endif

  // State register; a stall holds the current state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEQ_IDLE;
    end else if (advance) begin
      state <= next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state = state;
    case (state)
      SEQ_IDLE: begin
        if (start) begin
          next_state = SEQ_READ;
        end else begin
          next_state = SEQ_IDLE;
        end
      end
      SEQ_READ: begin
        if (counter == CNT_MAX) begin
          next_state = SEQ_DRAIN;
        end else begin
          next_state = SEQ_READ;
        end
      end
      SEQ_DRAIN: begin
        if (drain_cnt != DRAIN_LAST) begin
          next_state = SEQ_DRAIN;
        end else if (is_last_stage(stage_num, NUMSTAGES)) begin
          next_state = SEQ_DONE;
        end else begin
          next_state = SEQ_READ;
        end
      end
      SEQ_DONE: begin
        next_state = SEQ_IDLE;
      end
      default: begin
        next_state = SEQ_IDLE;
      end
    endcase
  end

  // Address counter, stage number and drain counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      counter   <= {CW{1'b0}};
      stage_num <= STAGE0;
      drain_cnt <= 3'd0;
    end else if (advance) begin
      case (state)
        SEQ_IDLE: begin
          counter   <= {CW{1'b0}};
          stage_num <= STAGE0;
          drain_cnt <= 3'd0;
        end
        SEQ_READ: begin
          // Wraps to zero on the last read, ready for the next stage.
          counter   <= counter + CNT_ONE;
          drain_cnt <= 3'd0;
        end
        SEQ_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            drain_cnt <= 3'd0;
            // The last stage keeps its number through DONE.
            if (!is_last_stage(stage_num, NUMSTAGES)) begin
              stage_num <= stage_num + 3'd1;
            end
          end else begin
            drain_cnt <= drain_cnt + 3'd1;
          end
        end
        SEQ_DONE: begin
          counter   <= {CW{1'b0}};
          stage_num <= STAGE0;
          drain_cnt <= 3'd0;
        end
        default: begin
          counter   <= {CW{1'b0}};
          stage_num <= STAGE0;
          drain_cnt <= 3'd0;
        end
      endcase
    end
  end

  // Output decode from the upcoming state, so the flops below line up with state.
  always_comb begin
    rd_en_nxt = 1'b0;
    done_nxt  = 1'b0;
    ready_nxt = 1'b0;
    case (next_state)
      SEQ_IDLE:  ready_nxt = 1'b1;
      SEQ_READ:  rd_en_nxt = 1'b1;
      SEQ_DRAIN: rd_en_nxt = 1'b0;
      SEQ_DONE:  done_nxt  = 1'b1;
      default:   ready_nxt = 1'b1;
    endcase
  end

  // Output flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else if (advance) begin
      rd_en_q <= rd_en_nxt;
      done_q  <= done_nxt;
      ready_q <= ready_nxt;
      busy_q  <= ~ready_nxt;
    end
  end

  // Write side: the read-side control word, delayed by the butterfly latency.
  assign dl_in = {rd_en_q, counter, stage_num};

  ctrl_delay_line #(
    .DEPTH (BFLY_LAT),
    .WIDTH (DW)
  ) u_wr_delay (
    .clk  (clk),
    .clr  (rst),
    .en   (advance),
    .din  (dl_in),
    .dout (dl_out)
  );

  assign wr_en_raw  = dl_out[DW-1];
  assign wr_counter = dl_out[DW-2:3];
  assign wr_stage   = dl_out[2:0];

  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;

`ifdef STAGE_SEQ_STALL_EN
  // No bank access may happen while the pipeline is frozen.
  assign rd_en = rd_en_q & ~stall;
  assign wr_en = wr_en_raw & ~stall;
`else
  assign rd_en = rd_en_q;
  assign wr_en = wr_en_raw;
`endif

endmodule

// File: tb/tb_stage_sequencer.sv
// tb_stage_sequencer -- self-checking bench for stage_sequencer.
// Instance a uses the default parameters, instance b uses BFLY_LAT=1.
module tb_stage_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start_a, start_b;
`ifdef STAGE_SEQ_STALL_EN
  logic stall;
`endif

  logic       ready_a, busy_a, done_a, rd_a, wr_a;
  logic [2:0] counter_a, stage_a, wcnt_a, wstg_a;
  logic       ready_b, busy_b, done_b, rd_b, wr_b;
  logic [2:0] counter_b, stage_b, wcnt_b, wstg_b;

  stage_sequencer #(.NUMSTAGES(5), .BFLY_LAT(2)) dut_a (
    .clk(clk), .rst(rst), .start(start_a),
`ifdef STAGE_SEQ_STALL_EN
    .stall(stall),
`endif
    .ready(ready_a), .busy(busy_a), .done(done_a),
    .counter(counter_a), .stage_num(stage_a), .rd_en(rd_a),
    .wr_counter(wcnt_a), .wr_stage(wstg_a), .wr_en(wr_a)
  );

  stage_sequencer #(.NUMSTAGES(5), .BFLY_LAT(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b),
`ifdef STAGE_SEQ_STALL_EN
    .stall(stall),
`endif
    .ready(ready_b), .busy(busy_b), .done(done_b),
    .counter(counter_b), .stage_num(stage_b), .rd_en(rd_b),
    .wr_counter(wcnt_b), .wr_stage(wstg_b), .wr_en(wr_b)
  );

  typedef struct packed {
    logic       rd;
    logic [2:0] cnt;
    logic [2:0] stg;
    logic       wr;
    logic [2:0] wcnt;
    logic [2:0] wstg;
    logic       done;
    logic       ready;
    logic       busy;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t exp;
  } vec_t;

  int   n_chk  = 0;
  int   n_pass = 0;
  obs_t q_a[$];
  obs_t q_b[$];
  obs_t snap [0:63];
  vec_t vecs [10];
  obs_t reset_obs;

  function automatic obs_t mk(logic rd, logic [2:0] cnt, logic [2:0] stg, logic wr,
                              logic [2:0] wc, logic [2:0] ws, logic d, logic r, logic b);
    obs_t o;
    o.rd = rd; o.cnt = cnt; o.stg = stg; o.wr = wr; o.wcnt = wc; o.wstg = ws;
    o.done = d; o.ready = r; o.busy = b;
    return o;
  endfunction

  // Read-side view at cycle c of a 5-stage run started in cycle 0.
  function automatic obs_t rside(int c, int lat);
    obs_t o;
    int per, total, k;
    o = '0;
    per = 8 + lat;
    total = 5 * per + 1;
    if (c <= 0 || c > total) begin
      o.ready = 1'b1;
    end else begin
      o.busy = 1'b1;
      if (c == total) begin
        o.done = 1'b1;
        o.stg  = 3'd4;
      end else begin
        k = c - 1;
        o.stg = 3'(k / per);
        if ((k % per) < 8) begin
          o.rd  = 1'b1;
          o.cnt = 3'(k % per);
        end
      end
    end
    return o;
  endfunction

  function automatic obs_t model(int c, int lat);
    obs_t r, w;
    r = rside(c, lat);
    w = rside(c - lat, lat);
    r.wr = w.rd; r.wcnt = w.cnt; r.wstg = w.stg;
    return r;
  endfunction

  function automatic obs_t sample_a();
    return mk(rd_a, counter_a, stage_a, wr_a, wcnt_a, wstg_a, done_a, ready_a, busy_a);
  endfunction

  function automatic obs_t sample_b();
    return mk(rd_b, counter_b, stage_b, wr_b, wcnt_b, wstg_b, done_b, ready_b, busy_b);
  endfunction

  task automatic chk_obs(string name, int c, obs_t got, obs_t exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", name, c, got, exp);
  endtask

  task automatic chk_val(string name, int c, int got, int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0d expected %0d", name, c, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
`ifdef STAGE_SEQ_STALL_EN
    stall = 1'b0;
`endif
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n_done, first_done;
    logic rd_gap;

    reset_obs = mk(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0);
    vecs[0] = '{1,  mk(1'b1, 3'd0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1)};
    vecs[1] = '{3,  mk(1'b1, 3'd2, 3'd0, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1)};
    vecs[2] = '{8,  mk(1'b1, 3'd7, 3'd0, 1'b1, 3'd5, 3'd0, 1'b0, 1'b0, 1'b1)};
    vecs[3] = '{9,  mk(1'b0, 3'd0, 3'd0, 1'b1, 3'd6, 3'd0, 1'b0, 1'b0, 1'b1)};
    vecs[4] = '{10, mk(1'b0, 3'd0, 3'd0, 1'b1, 3'd7, 3'd0, 1'b0, 1'b0, 1'b1)};
    vecs[5] = '{11, mk(1'b1, 3'd0, 3'd1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1)};
    vecs[6] = '{13, mk(1'b1, 3'd2, 3'd1, 1'b1, 3'd0, 3'd1, 1'b0, 1'b0, 1'b1)};
    vecs[7] = '{50, mk(1'b0, 3'd0, 3'd4, 1'b1, 3'd7, 3'd4, 1'b0, 1'b0, 1'b1)};
    vecs[8] = '{51, mk(1'b0, 3'd0, 3'd4, 1'b0, 3'd0, 3'd4, 1'b1, 1'b0, 1'b1)};
    vecs[9] = '{52, mk(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 3'd4, 1'b0, 1'b1, 1'b0)};

    // Reset state, then one full run on both instances against the model.
    do_reset();
    chk_obs("reset_a", 0, sample_a(), reset_obs);
    chk_obs("reset_b", 0, sample_b(), reset_obs);
    start_a = 1'b1;
    start_b = 1'b1;
    for (int c = 1; c <= 56; c++) begin
      q_a.push_back(model(c, 2));
      q_b.push_back(model(c, 1));
      tick();
      start_a = 1'b0;
      start_b = 1'b0;
      snap[c] = sample_a();
      chk_obs("run_lat2", c, snap[c], q_a.pop_front());
      chk_obs("run_lat1", c, sample_b(), q_b.pop_front());
    end

    // Hand-computed spot vectors from the same run.
    for (int i = 0; i < 10; i++) begin
      chk_obs("vec", vecs[i].cyc, snap[vecs[i].cyc], vecs[i].exp);
    end

    // start held high for the whole run: one transform, restart only from IDLE.
    do_reset();
    start_a = 1'b1;
    n_done = 0;
    first_done = -1;
    rd_gap = 1'b0;
    for (int c = 1; c <= 53; c++) begin
      tick();
      if (done_a) begin
        n_done++;
        if (first_done < 0) first_done = c;
      end
      if (c >= 49 && c <= 52 && rd_a) rd_gap = 1'b1;
      if (c == 53) chk_val("held_restart", c, int'({rd_a, stage_a, counter_a}), int'({1'b1, 3'd0, 3'd0}));
    end
    start_a = 1'b0;
    chk_val("held_done_count", 52, n_done, 1);
    chk_val("held_done_cycle", 52, first_done, 51);
    chk_val("held_no_early_read", 52, int'(rd_gap), 0);

    // Reset in the middle of stage 2.
    do_reset();
    start_a = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      tick();
      start_a = 1'b0;
    end
    chk_val("mid_stage", 25, int'({rd_a, stage_a, counter_a}), int'({1'b1, 3'd2, 3'd4}));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_obs("mid_reset", 26, sample_a(), reset_obs);
    for (int c = 27; c <= 36; c++) begin
      tick();
      chk_obs("post_reset_idle", c, sample_a(), reset_obs);
    end

`ifdef STAGE_SEQ_STALL_EN
    // Stall for cycles 5-7 of a run.
    do_reset();
    start_a = 1'b1;
    first_done = -1;
    for (int c = 1; c <= 56; c++) begin
      tick();
      start_a = 1'b0;
      stall = (c >= 5 && c <= 7);
      #1;
      if (c == 5 || c == 7) chk_val("stall_hold", c, int'({rd_a, counter_a}), int'({1'b0, 3'd4}));
      if (c == 8) chk_val("stall_resume", c, int'({rd_a, counter_a}), int'({1'b1, 3'd4}));
      if (done_a && first_done < 0) first_done = c;
    end
    stall = 1'b0;
    chk_val("stall_done_cycle", 56, first_done, 54);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/stage_sequencer.md
STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 SHALL have parameter NUMSTAGES, default 5, number of radix-2 stages (log2 of transform size).
REQ-002 SHALL have parameter BFLY_LAT, default 2, butterfly pipeline latency in cycles (range 1..7).
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  request to run one full transform; sampled only in IDLE.
REQ-006 ready  output  1  high in IDLE.
REQ-007 busy  output  1  high in any state other than IDLE.
REQ-008 done  output  1  one-cycle pulse at transform completion.
REQ-009 counter  output  NUMSTAGES-2  read-side bank address counter, feeds address generator.
REQ-010 stage_num  output  3  read-side current stage.
REQ-011 rd_en  output  1  bank read strobe.
REQ-012 wr_counter  output  NUMSTAGES-2  counter delayed by BFLY_LAT cycles.
REQ-013 wr_stage  output  3  stage_num delayed by BFLY_LAT cycles.
REQ-014 wr_en  output  1  rd_en delayed by BFLY_LAT cycles.
REQ-015 stall  input  1  pipeline freeze; present only with STAGE_SEQ_STALL_EN.

Function
REQ-016 States: IDLE, READ, DRAIN, DONE.
REQ-017 IDLE, start=1 -> READ next cycle with counter=0, stage_num=0; start=0 -> stay.
REQ-018 READ: rd_en=1; counter increments by 1 each cycle.
REQ-019 READ with counter = all-ones -> DRAIN; counter wraps to 0.
REQ-020 DRAIN: rd_en=0; lasts exactly BFLY_LAT cycles, so all writes of a stage complete before the next stage reads.
REQ-021 DRAIN end with stage_num < NUMSTAGES-1 -> READ, stage_num increments by 1.
REQ-022 DRAIN end with stage_num = NUMSTAGES-1 -> DONE.
REQ-023 DONE: done=1 for one cycle, then IDLE; stage_num returns to 0.
REQ-024 wr_en, wr_counter and wr_stage equal rd_en, counter and stage_num from BFLY_LAT cycles earlier.
REQ-025 start while busy is ignored, with no queuing.
REQ-026 Start-to-done latency is NUMSTAGES*(2^(NUMSTAGES-2)+BFLY_LAT)+1 cycles: 51 with defaults.
REQ-027 Counter arithmetic is modulo 2^(NUMSTAGES-2); stage_num never exceeds NUMSTAGES-1.

Reset
REQ-028 rst=1 forces IDLE next edge, in any state, including mid-stage.
REQ-029 Reset values: counter=0, stage_num=0, rd_en=0, wr_en=0, wr_counter=0, wr_stage=0, done=0, busy=0, ready=1.
REQ-030 Reset clears the whole delay line, so no stale wr_en after reset.

Configuration
REQ-031 Macro STAGE_SEQ_STALL_EN defined: stall=1 freezes state, counter, stage_num, DRAIN count and delay line; rd_en and wr_en forced 0 while stalled; operation resumes unchanged when stall=0.
REQ-032 Macro STAGE_SEQ_STALL_EN undefined: no stall port; behaviour equals stall tied 0.

Structure
REQ-033 Shared package fft_pkg holds the NUMSTAGES default, stage constants STAGE0..STAGE4 (3'b000..3'b100) and the sequencer state encoding.
REQ-034 The write-side delay is one sub-module, ctrl_delay_line: parameterised depth and width, with synchronous clear and enable.

Verification
REQ-035 Reset, then start pulse at cycle 0 -> rd_en high cycles 1-8, counter 0..7, stage_num 0; DRAIN cycles 9-10; stage 1 reads from cycle 11.
REQ-036 Same run -> wr_en high cycles 3-10 with wr_counter 0..7; done=1 at cycle 51 only; ready=1 at cycle 52.
REQ-037 start held high for the whole run -> exactly one transform, no second READ before the cycle-51 done; new run begins only if start is still high in IDLE.
REQ-038 rst=1 at cycle 25 (stage 2 mid-read) -> cycle 26: IDLE, all outputs at reset values; wr_en stays 0 until next start.
REQ-039 With STAGE_SEQ_STALL_EN, stall=1 cycles 5-7 -> counter holds 4, rd_en=0 for cycles 5-7; done moves to cycle 54.
REQ-040 BFLY_LAT=1 build -> wr_en trails rd_en by 1 cycle; DRAIN 1 cycle; done at cycle 46.
